// File: rtl/key_pulse_pkg.sv
// Shared types and defaults for the pushbutton conditioning stage.
package key_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam int DEBOUNCE_50MHZ_20MS = 1000000;
    localparam int SYNC_DEPTH_DEFAULT  = 2;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_pulse_sync_ff.sv
// N-stage synchroniser with async active-low reset to a configurable value.
module sync_ff #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_sync <= {STAGES{RST_VAL}};
        else
            r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/key_pulse.sv
// Pushbutton synchroniser + debouncer producing a level and press/release strobes.
// Define KEY_PULSE_REPEAT_EN to emit auto-repeat press strobes while held.
module key_pulse
    import key_pulse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS,
    parameter int SYNC_STAGES     = SYNC_DEPTH_DEFAULT,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic CLOCK_50,
    input  logic Resetn,
    input  logic key_n,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_PULSE_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
`endif

    logic             w_key_sync_n;
    logic             w_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pressed;
    logic             r_press_pulse;
    logic             r_release_pulse;
`ifdef KEY_PULSE_REPEAT_EN
    logic             r_rep;
`endif

    // Resets to released so no press is seen while the chain fills.
    sync_ff #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES),
        .RST_VAL(1'b1)
    ) u_sync (
        .i_clk  (CLOCK_50),
        .i_rst_n(Resetn),
        .i_d    (key_n),
        .o_q    (w_key_sync_n)
    );

    assign w_s = ~w_key_sync_n;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state         <= IDLE;
            r_cnt           <= '0;
            r_pressed       <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
`ifdef KEY_PULSE_REPEAT_EN
            r_rep           <= 1'b0;
`endif
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_s) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == DB_LAST) begin
                        r_state       <= HELD;
                        r_cnt         <= '0;
                        r_pressed     <= 1'b1;
                        r_press_pulse <= 1'b1;
`ifdef KEY_PULSE_REPEAT_EN
                        r_rep         <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_s) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
`ifdef KEY_PULSE_REPEAT_EN
                    // First strobe after the delay, then every period.
                    else if (r_cnt == (r_rep ? RP_LAST : RD_LAST)) begin
                        r_press_pulse <= 1'b1;
                        r_cnt         <= '0;
                        r_rep         <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (w_s) begin
                        r_state <= HELD;
                        r_cnt   <= '0;
`ifdef KEY_PULSE_REPEAT_EN
                        r_rep   <= 1'b0;
`endif
                    end else if (r_cnt == DB_LAST) begin
                        r_state         <= IDLE;
                        r_cnt           <= '0;
                        r_pressed       <= 1'b0;
                        r_release_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;

endmodule

// File: tb/tb_key_pulse.sv
// Scoreboard bench for key_pulse: stimulus queues expected strobes, a monitor checks them.
module tb_key_pulse;

    localparam int DB  = 4;
    localparam int SS  = 2;
    localparam int RD  = 10;
    localparam int RP  = 3;
    localparam int LAT = SS + DB + 1;
`ifdef KEY_PULSE_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic key_n = 1'b1;
    logic pressed, press_pulse, release_pulse;

    key_pulse #(
        .DEBOUNCE_CYCLES(DB),
        .SYNC_STAGES    (SS),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLOCK_50     (clk),
        .Resetn       (rst_n),
        .key_n        (key_n),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit rel;
        int at;
    } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input bit rel, input int at);
        ev_t e;
        e.rel = rel;
        e.at  = at;
        exp_q.push_back(e);
    endfunction

    // Auto-repeat strobes between HELD entry edge and HELD exit edge.
    function automatic void push_repeats(input int enter, input int leave);
        int t;
        if (REP_EN) begin
            t = enter + RD;
            while (t < leave) begin
                push(1'b0, t);
                t += RP;
            end
        end
    endfunction

    always @(negedge clk) begin
        if (press_pulse || release_pulse) begin
            check("strobe_exclusive", int'(press_pulse & release_pulse), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: got press=%0b release=%0b at cycle %0d, want none",
                         press_pulse, release_pulse, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_kind_release", int'(release_pulse), int'(mon_e.rel));
                check("strobe_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        int c, d, g, r;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("reset_pressed", int'(pressed), 0);
        check("reset_press_pulse", int'(press_pulse), 0);
        check("reset_release_pulse", int'(release_pulse), 0);
        step(3);
        rst_n = 1'b1;
        step(3);

        // Clean press, 20-cycle hold, clean release
        c = cyc;
        d = c + LAT + 20;
        push(1'b0, c + LAT);
        push_repeats(c + LAT, d + 3);
        push(1'b1, d + LAT);
        key_n = 1'b0;
        wait_until(c + LAT - 1);
        check("press_pressed_before", int'(pressed), 0);
        wait_until(c + LAT);
        check("press_pressed_after", int'(pressed), 1);
        wait_until(d);
        key_n = 1'b1;
        wait_until(d + LAT - 1);
        check("release_pressed_before", int'(pressed), 1);
        wait_until(d + LAT);
        check("release_pressed_after", int'(pressed), 0);
        step(5);

        // Bounce shorter than the debounce window
        key_n = 1'b0; step(3);
        key_n = 1'b1; step(2);
        key_n = 1'b0; step(2);
        key_n = 1'b1; step(10);
        check("bounce_pressed", int'(pressed), 0);

        // Release glitch while held
        c = cyc;
        g = c + LAT + 5;
        d = g + 20;
        push(1'b0, c + LAT);
        push_repeats(c + LAT, g + 3);
        push_repeats(g + 5, d + 3);
        push(1'b1, d + LAT);
        key_n = 1'b0;
        wait_until(g);
        key_n = 1'b1; step(2);
        key_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("glitch_pressed", int'(pressed), 1);
            step(1);
        end
        wait_until(d);
        key_n = 1'b1;
        wait_until(d + LAT);
        check("glitch_release_pressed", int'(pressed), 0);
        step(5);

        // Long hold (repeat strobes when enabled)
        c = cyc;
        d = c + 35;
        push(1'b0, c + LAT);
        push_repeats(c + LAT, d + 3);
        push(1'b1, d + LAT);
        key_n = 1'b0;
        wait_until(d);
        key_n = 1'b1;
        wait_until(d + LAT);
        check("hold_release_pressed", int'(pressed), 0);
        step(5);

        // Reset during PRESS_WAIT, key kept low across reset
        c = cyc;
        key_n = 1'b0;
        wait_until(c + 5);
        rst_n = 1'b0;
        #1;
        check("rst_pw_pressed", int'(pressed), 0);
        check("rst_pw_press_pulse", int'(press_pulse), 0);
        step(3);
        r = cyc;
        push(1'b0, r + LAT);
        rst_n = 1'b1;
        wait_until(r + LAT);
        check("rst_repress_pressed", int'(pressed), 1);

        // Asynchronous reset while held clears the level without a strobe
        step(2);
        rst_n = 1'b0;
        #1;
        check("rst_held_pressed", int'(pressed), 0);
        check("rst_held_release_pulse", int'(release_pulse), 0);
        key_n = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(10);
        check("post_reset_pressed", int'(pressed), 0);

        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/key_pulse.md
Name: key_pulse

Overview:
- Upstream conditioning stage for the DE-series pushbuttons. It feeds the counter stage's enable or step input.
- Takes one raw active-low KEY input and synchronises it into the clock domain.
- Debounces it with a saturating cycle counter and a 4-state FSM.
- Emits a debounced level plus single-cycle press and release strobes, so downstream counters advance exactly once per physical press.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles the synchronised input must stay stable before a level change is accepted (20 ms at 50 MHz). Must be >= 2.
- SYNC_STAGES, 2: synchroniser flop depth. Must be >= 2.
- REPEAT_DELAY, 25000000: cycles held before the first auto-repeat strobe. Used only with the optional feature.
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat strobes. Used only with the optional feature.

Ports:
- CLOCK_50  input  1  50 MHz system clock; all flops on rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- key_n  input  1  raw pushbutton, 0 = pressed. Asynchronous and bouncing.
- pressed  output  1  debounced level, 1 = held.
- press_pulse  output  1  one-cycle strobe on accepted press (and on repeats, if enabled).
- release_pulse  output  1  one-cycle strobe on accepted release.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - all synchroniser flops = 1 (released);
  - state = IDLE, cnt = 0;
  - pressed = 0, press_pulse = 0, release_pulse = 0.
- Reset mid-press discards all progress. No strobe is emitted on reset entry or exit.
- Synchroniser: key_n passes through SYNC_STAGES flops. s = inverted last stage (1 = pressed).
- Counter: cnt width = $clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1), unsigned. It never wraps: every state exit clears it.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: if s=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - s=0: return to IDLE, cnt=0 (bounce rejected, no strobe).
    - s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, cnt=0.
    - otherwise: cnt++.
  - HELD: if s=0, go to RELEASE_WAIT with cnt=0.
  - RELEASE_WAIT:
    - s=1: return to HELD, cnt=0 (no strobe).
    - s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - otherwise: cnt++.
- Outputs (all registered):
  - pressed = 1 in HELD and RELEASE_WAIT.
  - press_pulse = 1 for exactly one cycle after the PRESS_WAIT->HELD edge.
  - release_pulse = 1 for exactly one cycle after the RELEASE_WAIT->IDLE edge.
- Latency: for a clean press, press_pulse is high in the cycle following clock edge SYNC_STAGES+DEBOUNCE_CYCLES+1. Edges are counted from the first edge that samples key_n=0. Release is symmetric.
- Strobe exclusivity: press_pulse and release_pulse are never high in the same cycle.
- Minimum spacing between any press_pulse and the following release_pulse is DEBOUNCE_CYCLES cycles.
- Pulses shorter than DEBOUNCE_CYCLES synchronised cycles never change pressed.
- key_n held permanently low from reset release: a press is reported once, after the standard latency.

Optional Feature:
- Macro: KEY_PULSE_REPEAT_EN.
- When defined, HELD counts with cnt:
  - after REPEAT_DELAY cycles in HELD, a press_pulse is emitted;
  - then one press_pulse every REPEAT_PERIOD cycles while in HELD;
  - entering RELEASE_WAIT stops repeating;
  - returning RELEASE_WAIT->HELD restarts the REPEAT_DELAY count from 0.
- When undefined, HELD does not count, exactly one press_pulse per accepted press is emitted, and the REPEAT_* parameters are ignored.

Decomposition:
- Package key_pulse_pkg holds:
  - typedef enum logic [1:0] state_t {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT};
  - localparam defaults DEBOUNCE_50MHZ_20MS = 1000000 and SYNC_DEPTH_DEFAULT = 2.
- One sub-module is natural: sync_ff. It is a parameterised N-stage synchroniser with an async active-low reset and a reset value parameter. It is reused for the SW inputs later.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=10, REPEAT_PERIOD=3.
1. Clean press: key_n 1->0 at edge 0, held -> press_pulse high only in the cycle after edge 7 (latency SYNC_STAGES+DEBOUNCE_CYCLES+1), pressed=1 from the same cycle, release_pulse=0.
2. Bounce reject: key_n low for 3 cycles, high 2 cycles, low 2 cycles, then high -> pressed stays 0 and no strobe ever fires.
3. Clean release after 20-cycle hold: key_n 0->1 -> release_pulse high for exactly one cycle, 7 edges after key_n is first sampled 1. pressed falls in the same cycle.
4. Release glitch: while HELD, key_n high for 2 cycles then low -> pressed stays 1, no release_pulse.
5. Reset mid-operation: Resetn=0 while in PRESS_WAIT with cnt=2 -> all outputs 0 immediately (asynchronous). After Resetn=1 with key_n still 0, press_pulse fires once after full latency.
6. With KEY_PULSE_REPEAT_EN defined, hold 30 cycles -> press_pulses in the cycles after HELD entry, +10, +13, +16, +19, +22, +25, +28. Without the macro, only one press_pulse.
